// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipeline hazard/sequencing controller.
package pipe_pkg;

    localparam int REG_W_DFLT = 5;

    typedef enum logic [1:0] {
        RUN      = 2'b00,
        MEM_WAIT = 2'b01
    } state_t;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

endpackage

// File: rtl/pipe_ctrl_if.sv
// Hazard-controller bundle: pipeline stage info in, register-bank hold/clear and forward selects out.
interface pipe_ctrl_if #(parameter int REG_W = pipe_pkg::REG_W_DFLT);

    logic [REG_W-1:0] id_rs, id_rt, ex_rs, ex_rt, ex_rd, mem_rd, wb_rd;
    logic             id_use_rs, id_use_rt;
    logic             id_md_start, id_md_div, id_md_read;
    logic             ex_regwrite, ex_memread, mem_regwrite, wb_regwrite;
    logic             ex_branch_taken;
    logic             dmem_req, dmem_ack;

    logic             pc_hold;
    logic             ifid_hold, ifid_clear, idex_hold, idex_clear;
    logic             exmem_hold, exmem_clear, memwb_hold, memwb_clear;
    logic [1:0]       fwd_a, fwd_b;
    logic             md_busy;
    logic [31:0]      stall_cycles;

    // datapath side
    modport master (
        output id_rs, id_rt, ex_rs, ex_rt, ex_rd, mem_rd, wb_rd,
               id_use_rs, id_use_rt, id_md_start, id_md_div, id_md_read,
               ex_regwrite, ex_memread, mem_regwrite, wb_regwrite,
               ex_branch_taken, dmem_req, dmem_ack,
        input  pc_hold, ifid_hold, ifid_clear, idex_hold, idex_clear,
               exmem_hold, exmem_clear, memwb_hold, memwb_clear,
               fwd_a, fwd_b, md_busy, stall_cycles
    );

    // controller side
    modport slave (
        input  id_rs, id_rt, ex_rs, ex_rt, ex_rd, mem_rd, wb_rd,
               id_use_rs, id_use_rt, id_md_start, id_md_div, id_md_read,
               ex_regwrite, ex_memread, mem_regwrite, wb_regwrite,
               ex_branch_taken, dmem_req, dmem_ack,
        output pc_hold, ifid_hold, ifid_clear, idex_hold, idex_clear,
               exmem_hold, exmem_clear, memwb_hold, memwb_clear,
               fwd_a, fwd_b, md_busy, stall_cycles
    );

endinterface

// File: rtl/pipe_fwd_unit.sv
// Per-operand EX forwarding compare; the youngest producer (EX/MEM) wins, r0 never forwards.
module pipe_fwd_unit
    import pipe_pkg::*;
#(
    parameter int REG_W = REG_W_DFLT
) (
    input  logic [REG_W-1:0] src,
    input  logic [REG_W-1:0] mem_rd,
    input  logic             mem_regwrite,
    input  logic [REG_W-1:0] wb_rd,
    input  logic             wb_regwrite,
    output logic [1:0]       sel
);

    always_comb begin
        sel = FWD_RF;
        if (mem_regwrite && (mem_rd != '0) && (mem_rd == src))
            sel = FWD_MEM;
        else if (wb_regwrite && (wb_rd != '0) && (wb_rd == src))
            sel = FWD_WB;
    end

endmodule

// File: rtl/pipe_ctrl.sv
// 5-stage MIPS hazard/sequencing controller: freeze, flush, interlocks, MD busy counter, stall counter.
// PIPE_CTRL_FWD_EN enables EX forwarding; without it every EX/MEM RAW match interlocks.
module pipe_ctrl
    import pipe_pkg::*;
#(
    parameter int REG_W      = REG_W_DFLT,
    parameter int MUL_CYCLES = 4,
    parameter int DIV_CYCLES = 32
) (
    input  logic       clk,
    input  logic       rst_n,
    pipe_ctrl_if.slave bus
);

    localparam int MD_MAX = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int CW     = $clog2(MD_MAX + 1);

    state_t      state, state_nxt;
    logic [CW-1:0] md_cnt;
    logic [31:0] stall_q;
    logic        freeze, flush, interlock, md_load, busy;
    logic        ex_hit, load_use, md_il, raw_il;

    assign freeze = bus.dmem_req & ~bus.dmem_ack;
    assign flush  = bus.ex_branch_taken;
    assign busy   = (md_cnt != '0);

    assign ex_hit = (bus.ex_rd != '0) &
                    ((bus.id_use_rs & (bus.id_rs == bus.ex_rd)) |
                     (bus.id_use_rt & (bus.id_rt == bus.ex_rd)));
    assign load_use = bus.ex_memread & ex_hit;
    assign md_il    = busy & (bus.id_md_start | bus.id_md_read);

`ifdef PIPE_CTRL_FWD_EN
    logic [1:0][REG_W-1:0] fwd_src;
    logic [1:0][1:0]       fwd_sel;
    logic                  unused_nofwd;

    assign unused_nofwd = bus.ex_regwrite;
    assign raw_il       = load_use;
    assign fwd_src      = {bus.ex_rt, bus.ex_rs};

    for (genvar g = 0; g < 2; g++) begin : g_fwd
        pipe_fwd_unit #(.REG_W(REG_W)) u_fwd (
            .src          (fwd_src[g]),
            .mem_rd       (bus.mem_rd),
            .mem_regwrite (bus.mem_regwrite),
            .wb_rd        (bus.wb_rd),
            .wb_regwrite  (bus.wb_regwrite),
            .sel          (fwd_sel[g])
        );
    end

    assign bus.fwd_a = rst_n ? fwd_sel[0] : FWD_RF;
    assign bus.fwd_b = rst_n ? fwd_sel[1] : FWD_RF;
`else
    logic mem_hit;
    logic unused_fwd;

    // WB is never checked: the register file writes before it is read
    assign mem_hit = (bus.mem_rd != '0) &
                     ((bus.id_use_rs & (bus.id_rs == bus.mem_rd)) |
                      (bus.id_use_rt & (bus.id_rt == bus.mem_rd)));
    assign raw_il     = load_use | (bus.ex_regwrite & ex_hit) | (bus.mem_regwrite & mem_hit);
    assign unused_fwd = ^{bus.ex_rs, bus.ex_rt, bus.wb_rd, bus.wb_regwrite};
    assign bus.fwd_a  = FWD_RF;
    assign bus.fwd_b  = FWD_RF;
`endif

    assign interlock = raw_il | md_il;
    assign md_load   = bus.id_md_start & ~freeze & ~flush & ~interlock;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= RUN;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt       = state;
        bus.pc_hold     = 1'b0;
        bus.ifid_hold   = 1'b0;
        bus.ifid_clear  = 1'b0;
        bus.idex_hold   = 1'b0;
        bus.idex_clear  = 1'b0;
        bus.exmem_hold  = 1'b0;
        bus.exmem_clear = 1'b0;
        bus.memwb_hold  = 1'b0;
        bus.memwb_clear = 1'b0;

        case (state)
            RUN:      if (freeze)       state_nxt = MEM_WAIT;
            MEM_WAIT: if (bus.dmem_ack) state_nxt = RUN;
            default:                    state_nxt = RUN;
        endcase

        // priority: reset > freeze > flush > interlock
        if (!rst_n) begin
            bus.ifid_clear  = 1'b1;
            bus.idex_clear  = 1'b1;
            bus.exmem_clear = 1'b1;
            bus.memwb_clear = 1'b1;
        end else if (freeze) begin
            bus.pc_hold     = 1'b1;
            bus.ifid_hold   = 1'b1;
            bus.idex_hold   = 1'b1;
            bus.exmem_hold  = 1'b1;
            bus.memwb_clear = 1'b1;
        end else if (flush) begin
            bus.ifid_clear  = 1'b1;
            bus.idex_clear  = 1'b1;
        end else if (interlock) begin
            bus.pc_hold     = 1'b1;
            bus.ifid_hold   = 1'b1;
            bus.idex_clear  = 1'b1;
        end
    end

    // the MD unit keeps running while the pipeline is frozen
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       md_cnt <= '0;
        else if (md_load) md_cnt <= bus.id_md_div ? CW'(DIV_CYCLES) : CW'(MUL_CYCLES);
        else if (busy)    md_cnt <= md_cnt - 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                             stall_q <= '0;
        else if (bus.pc_hold && (stall_q != '1)) stall_q <= stall_q + 1'b1;
    end

    assign bus.md_busy      = rst_n & busy;
    assign bus.stall_cycles = stall_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed-vector bench for pipe_ctrl: stimulus pushes expectations, a negedge monitor pops and compares.
module tb_pipe_ctrl;
    import pipe_pkg::*;

`ifdef PIPE_CTRL_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    // {pc_hold, ifid_hold, ifid_clear, idex_hold, idex_clear, exmem_hold, exmem_clear, memwb_hold, memwb_clear}
    localparam logic [8:0] C_RUN   = 9'b000000000;
    localparam logic [8:0] C_IL    = 9'b110010000;
    localparam logic [8:0] C_FLUSH = 9'b001010000;
    localparam logic [8:0] C_FRZ   = 9'b110101001;
    localparam logic [8:0] C_RST   = 9'b001010101;

    typedef struct {
        string       name;
        logic [8:0]  ctrl;
        logic [1:0]  fa, fb;
        logic        busy;
        logic [31:0] stall;
        logic [1:0]  st;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0, failures = 0;
    logic [31:0] exp_stall = 0;
    exp_t q[$];

    always #5 clk = ~clk;

    pipe_ctrl_if #(.REG_W(5)) bus ();

    pipe_ctrl #(.REG_W(5), .MUL_CYCLES(4), .DIV_CYCLES(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic idle();
        bus.id_rs = '0; bus.id_rt = '0; bus.ex_rs = '0; bus.ex_rt = '0;
        bus.ex_rd = '0; bus.mem_rd = '0; bus.wb_rd = '0;
        bus.id_use_rs = 0; bus.id_use_rt = 0;
        bus.id_md_start = 0; bus.id_md_div = 0; bus.id_md_read = 0;
        bus.ex_regwrite = 0; bus.ex_memread = 0; bus.mem_regwrite = 0; bus.wb_regwrite = 0;
        bus.ex_branch_taken = 0; bus.dmem_req = 0; bus.dmem_ack = 0;
    endtask

    task automatic chk(input string nm, input logic [8:0] c, input logic [1:0] fa,
                       input logic [1:0] fb, input logic busy, input logic [1:0] st);
        exp_t e;
        e.name = nm; e.ctrl = c; e.fa = fa; e.fb = fb; e.busy = busy;
        e.stall = exp_stall; e.st = st;
        q.push_back(e);
        if (c[8]) exp_stall++;
        @(posedge clk); #1;
    endtask

    task automatic cmp(input string nm, input string fld, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s.%s actual=%0h required=%0h", nm, fld, act, req);
        end
    endtask

    // monitor
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                cmp(e.name, "ctrl", 32'({bus.pc_hold, bus.ifid_hold, bus.ifid_clear, bus.idex_hold,
                    bus.idex_clear, bus.exmem_hold, bus.exmem_clear, bus.memwb_hold,
                    bus.memwb_clear}), 32'(e.ctrl));
                cmp(e.name, "fwd_a", 32'(bus.fwd_a), 32'(e.fa));
                cmp(e.name, "fwd_b", 32'(bus.fwd_b), 32'(e.fb));
                cmp(e.name, "md_busy", 32'(bus.md_busy), 32'(e.busy));
                cmp(e.name, "stall", bus.stall_cycles, e.stall);
                cmp(e.name, "state", 32'(logic'(dut.state[1])) << 1 | 32'(dut.state[0]), 32'(e.st));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        idle();
        repeat (2) @(posedge clk);
        #1;
        chk("reset", C_RST, 0, 0, 0, RUN);
        rst_n = 1'b1;
        chk("idle", C_RUN, 0, 0, 0, RUN);

        // load-use: one bubble, counted once
        bus.ex_memread = 1; bus.ex_regwrite = 1; bus.ex_rd = 5; bus.id_rs = 5; bus.id_use_rs = 1;
        chk("loaduse_rs", C_IL, 0, 0, 0, RUN);
        idle();
        chk("loaduse_after", C_RUN, 0, 0, 0, RUN);
        bus.ex_memread = 1; bus.ex_rd = 3; bus.id_rt = 3; bus.id_use_rt = 1;
        chk("loaduse_rt", C_IL, 0, 0, 0, RUN);
        idle();
        bus.ex_memread = 1; bus.ex_rd = 0; bus.id_rs = 0; bus.id_use_rs = 1;
        chk("loaduse_r0", C_RUN, 0, 0, 0, RUN);
        bus.ex_rd = 6; bus.id_rs = 6; bus.id_use_rs = 0;
        chk("loaduse_unused_src", C_RUN, 0, 0, 0, RUN);

        // flush beats load-use
        bus.ex_rd = 5; bus.id_rs = 5; bus.id_use_rs = 1; bus.ex_branch_taken = 1;
        chk("branch_over_lu", C_FLUSH, 0, 0, 0, RUN);
        idle();

        // memory wait: three unacked cycles then ack
        bus.dmem_req = 1;
        chk("mw0", C_FRZ, 0, 0, 0, RUN);
        chk("mw1", C_FRZ, 0, 0, 0, MEM_WAIT);
        chk("mw2", C_FRZ, 0, 0, 0, MEM_WAIT);
        bus.dmem_ack = 1;
        chk("mw_ack", C_RUN, 0, 0, 0, MEM_WAIT);
        idle();
        chk("mw_done", C_RUN, 0, 0, 0, RUN);

        // branch held through a freeze flushes on the ack cycle
        bus.dmem_req = 1; bus.ex_branch_taken = 1;
        chk("br_frz", C_FRZ, 0, 0, 0, RUN);
        bus.dmem_ack = 1;
        chk("br_ack", C_FLUSH, 0, 0, 0, MEM_WAIT);
        idle();
        bus.dmem_req = 1; bus.dmem_ack = 1;
        chk("req_ack_same", C_RUN, 0, 0, 0, RUN);
        idle();
        chk("req_ack_stay", C_RUN, 0, 0, 0, RUN);

        // forwarding / RAW
        bus.mem_rd = 7; bus.wb_rd = 7; bus.mem_regwrite = 1; bus.wb_regwrite = 1;
        bus.ex_rs = 7; bus.ex_rt = 0; bus.id_rs = 7; bus.id_use_rs = 1;
        chk("fwd_mem", FWD ? C_RUN : C_IL, FWD ? 2'b10 : 2'b00, 2'b00, 0, RUN);
        bus.mem_regwrite = 0; bus.ex_rt = 7;
        chk("fwd_wb", C_RUN, FWD ? 2'b01 : 2'b00, FWD ? 2'b01 : 2'b00, 0, RUN);
        bus.mem_rd = 0; bus.wb_rd = 0; bus.mem_regwrite = 1; bus.ex_rs = 0; bus.ex_rt = 0; bus.id_rs = 0;
        chk("fwd_r0", C_RUN, 0, 0, 0, RUN);
        idle();
        bus.ex_regwrite = 1; bus.ex_rd = 9; bus.id_rt = 9; bus.id_use_rt = 1;
        chk("raw_ex", FWD ? C_RUN : C_IL, 0, 0, 0, RUN);
        idle();

        // multiply: 4 busy cycles, a second start waits
        bus.id_md_start = 1;
        chk("mul_start", C_RUN, 0, 0, 0, RUN);
        bus.id_md_start = 0;
        chk("mul_b1", C_RUN, 0, 0, 1, RUN);
        bus.id_md_start = 1;
        chk("mul_restart", C_IL, 0, 0, 1, RUN);
        bus.id_md_start = 0;
        chk("mul_b3", C_RUN, 0, 0, 1, RUN);
        chk("mul_b4", C_RUN, 0, 0, 1, RUN);
        chk("mul_done", C_RUN, 0, 0, 0, RUN);

        // divide with mfhi waiting
        bus.id_md_start = 1; bus.id_md_div = 1;
        chk("div_start", C_RUN, 0, 0, 0, RUN);
        bus.id_md_start = 0; bus.id_md_read = 1;
        for (int i = 1; i <= 32; i++) chk("div_wait", C_IL, 0, 0, 1, RUN);
        chk("div_read", C_RUN, 0, 0, 0, RUN);
        idle();

        // divide with a 5-cycle freeze inside: latency unchanged
        bus.id_md_start = 1; bus.id_md_div = 1;
        chk("divf_start", C_RUN, 0, 0, 0, RUN);
        bus.id_md_start = 0; bus.id_md_read = 1;
        for (int i = 1; i <= 32; i++) begin
            bus.dmem_req = (i >= 10 && i <= 15);
            bus.dmem_ack = (i == 15);
            chk("divf_wait", (i >= 10 && i <= 14) ? C_FRZ : C_IL, 0, 0, 1,
                (i >= 11 && i <= 15) ? MEM_WAIT : RUN);
        end
        bus.dmem_req = 0; bus.dmem_ack = 0;
        chk("divf_read", C_RUN, 0, 0, 0, RUN);
        idle();

        // async reset in the middle of a divide and a memory wait
        bus.id_md_start = 1; bus.id_md_div = 1;
        chk("rst_div_start", C_RUN, 0, 0, 0, RUN);
        bus.id_md_start = 0;
        chk("rst_div_b1", C_RUN, 0, 0, 1, RUN);
        bus.dmem_req = 1;
        chk("rst_frz0", C_FRZ, 0, 0, 1, RUN);
        chk("rst_frz1", C_FRZ, 0, 0, 1, MEM_WAIT);
        rst_n = 1'b0;
        exp_stall = 0;
        chk("rst_mid", C_RST, 0, 0, 0, RUN);
        rst_n = 1'b1;
        idle();
        chk("rst_release", C_RUN, 0, 0, 0, RUN);

        @(negedge clk);
        #1;
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL drain actual=%0d required=0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
